// File: rtl/conv_pkg.sv
// conv_pkg: constants and helpers shared by the sliding-window generator and
// the downstream convolution stage.
//   DATA_WIDTH, K     : default pixel width and kernel size
//   IMG_W, IMG_H, S   : default image geometry and stride
//   cnt_w()           : counter width for a modulus n (at least 1 bit)
//   elem_lsb()        : LSB of window element (r, c) in the packed vector
package conv_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned K          = 3;
    localparam int unsigned IMG_W      = 8;
    localparam int unsigned IMG_H      = 8;
    localparam int unsigned S          = 1;

    // Bits needed to count 0..n-1; a 1-bit counter is kept for n <= 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packing convention: element r*k+c, r=0 top row, c=0 left column.
    function automatic int unsigned elem_lsb(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned kk,
                                             input int unsigned dw);
        return dw * (r * kk + c);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bundle of the window generator.
//   pix_in, pix_valid        : raster pixel stream (no backpressure)
//   activation1              : packed k*k window
//   win_valid, frame_done    : one-cycle strobes
// master = pixel source / window consumer, slave = window generator.
interface conv_window_gen_if #(
    parameter int unsigned data_width = conv_pkg::DATA_WIDTH,
    parameter int unsigned k          = conv_pkg::K
) ();

    logic [data_width-1:0]       pix_in;
    logic                        pix_valid;
    logic [k*k*data_width-1:0]   activation1;
    logic                        win_valid;
    logic                        frame_done;

    modport master (
        output pix_in,
        output pix_valid,
        input  activation1,
        input  win_valid,
        input  frame_done
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        output activation1,
        output win_valid,
        output frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, combinational read and synchronous
// write on a shared address. Contents are not reset.
//   clk          : clock
//   addr_i       : column address (read and write)
//   wr_en_i      : write wr_data_i at addr_i on the rising edge
//   wr_data_i    : write data
//   rd_data_c_o  : combinational read of addr_i (value before this edge's write)
module line_buffer #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 8,
    parameter int unsigned addr_w     = 3
) (
    input  logic                  clk,
    input  logic [addr_w-1:0]     addr_i,
    input  logic                  wr_en_i,
    input  logic [data_width-1:0] wr_data_i,
    output logic [data_width-1:0] rd_data_c_o
);

    logic [data_width-1:0] mem_q [depth];

    // Row storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream in, k x k sliding windows out at
// stride-aligned positions. Buffers k-1 rows in line buffers plus a k x k
// window register; outputs are registered with one cycle of latency.
//   clk          : clock, rising edge
//   global_rst   : asynchronous active-high reset
//   win_if       : slave side of conv_window_gen_if
//                  (pix_in/pix_valid in, activation1/win_valid/frame_done out)
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned k          = K,
    parameter int unsigned s          = S,
    parameter int unsigned img_w      = IMG_W,
    parameter int unsigned img_h      = IMG_H
) (
    input  logic             clk,
    input  logic             global_rst,
    conv_window_gen_if.slave win_if
);

    localparam int unsigned COL_W = cnt_w(img_w);
    localparam int unsigned ROW_W = cnt_w(img_h);
    localparam int unsigned PH_W  = cnt_w(s);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [PH_W-1:0]       cph_q, cph_d;
    logic [PH_W-1:0]       rph_q, rph_d;
    logic                  win_valid_q, win_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [data_width-1:0] win_q [k][k];
    logic [data_width-1:0] win_d [k][k];

    logic [data_width-1:0] lb_rd [k-1];
    logic [data_width-1:0] new_col [k];
    logic                  col_ok;
    logic                  row_ok;
    logic                  last_col;
    logic                  last_row;

    // Row store chain: buffer j holds the row j+1 above the current one.
    for (genvar j = 0; j < int'(k) - 1; j++) begin : g_lb
        if (j == 0) begin : g_first
            line_buffer #(
                .data_width (data_width),
                .depth      (img_w),
                .addr_w     (COL_W)
            ) u_lb (
                .clk         (clk),
                .addr_i      (col_q),
                .wr_en_i     (win_if.pix_valid),
                .wr_data_i   (win_if.pix_in),
                .rd_data_c_o (lb_rd[j])
            );
        end else begin : g_rest
            line_buffer #(
                .data_width (data_width),
                .depth      (img_w),
                .addr_w     (COL_W)
            ) u_lb (
                .clk         (clk),
                .addr_i      (col_q),
                .wr_en_i     (win_if.pix_valid),
                .wr_data_i   (lb_rd[j-1]),
                .rd_data_c_o (lb_rd[j])
            );
        end
    end

    // Incoming window column, top (oldest row) to bottom (current pixel).
    always_comb begin
        for (int r = 0; r < int'(k); r++) begin
            new_col[r] = '0;
        end
        for (int r = 0; r < int'(k) - 1; r++) begin
            new_col[r] = lb_rd[int'(k) - 2 - r];
        end
        new_col[k-1] = win_if.pix_in;
    end

    // Stride alignment from phase counters; phase is 0 until k-1 is reached.
    assign col_ok   = (col_q >= COL_W'(k - 1)) && (cph_q == '0);
    assign row_ok   = (row_q >= ROW_W'(k - 1)) && (rph_q == '0);
    assign last_col = (col_q == COL_W'(img_w - 1));
    assign last_row = (row_q == ROW_W'(img_h - 1));

    // Next-state: everything holds on bubbles, strobes default low.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        for (int r = 0; r < int'(k); r++) begin
            for (int c = 0; c < int'(k); c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end

        if (win_if.pix_valid) begin
            for (int r = 0; r < int'(k); r++) begin
                for (int c = 0; c < int'(k) - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][k-1] = new_col[r];
            end

            win_valid_d = col_ok && row_ok;

            if (last_col) begin
                col_d = '0;
                cph_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    rph_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    if (row_q < ROW_W'(k - 1)) begin
                        rph_d = '0;
                    end else if (rph_q == PH_W'(s - 1)) begin
                        rph_d = '0;
                    end else begin
                        rph_d = rph_q + PH_W'(1);
                    end
                end
            end else begin
                col_d = col_q + COL_W'(1);
                if (col_q < COL_W'(k - 1)) begin
                    cph_d = '0;
                end else if (cph_q == PH_W'(s - 1)) begin
                    cph_d = '0;
                end else begin
                    cph_d = cph_q + PH_W'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < int'(k); r++) begin
                for (int c = 0; c < int'(k); c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            for (int r = 0; r < int'(k); r++) begin
                for (int c = 0; c < int'(k); c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    assign win_if.win_valid  = win_valid_q;
    assign win_if.frame_done = frame_done_q;

    // Flatten the window register into the packed activation vector.
    for (genvar r = 0; r < int'(k); r++) begin : g_row
        for (genvar c = 0; c < int'(k); c++) begin : g_col
            assign win_if.activation1[elem_lsb(r, c, k, data_width) +: data_width] = win_q[r][c];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: drives the same pixel stream into a stride-1 and a
// stride-2 instance (k=3, 5x5 image) and compares every output cycle with a
// reference that stores the frame as a 2-D array and cuts windows out of it.
module tb_conv_window_gen;

    localparam int DW = 32;
    localparam int KK = 3;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int AW = DW * KK * KK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;

    always #5 clk = ~clk;

    conv_window_gen_if #(.data_width(DW), .k(KK)) bus_a ();
    conv_window_gen_if #(.data_width(DW), .k(KK)) bus_b ();

    assign bus_a.pix_in    = pix_in;
    assign bus_a.pix_valid = pix_valid;
    assign bus_b.pix_in    = pix_in;
    assign bus_b.pix_valid = pix_valid;

    conv_window_gen #(.data_width(DW), .k(KK), .s(1), .img_w(IW), .img_h(IH)) dut_a (
        .clk        (clk),
        .global_rst (rst),
        .win_if     (bus_a)
    );

    conv_window_gen #(.data_width(DW), .k(KK), .s(2), .img_w(IW), .img_h(IH)) dut_b (
        .clk        (clk),
        .global_rst (rst),
        .win_if     (bus_b)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] img [IH][IW];
    int            mr = 0;
    int            mc = 0;
    int            win_cnt [2];
    int            fd_seen = 0;
    int            fd_exp_total = 0;
    int            frame_base = -1;
    int            win_idx_a = 0;
    logic [AW-1:0] exp_act [2];
    logic          exp_wv [2];
    logic          exp_fd = 1'b0;

    task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Window whose bottom-right pixel is (rr, cc), cut from the stored frame.
    function automatic logic [AW-1:0] model_window(input int rr, input int cc);
        logic [AW-1:0] res;
        res = '0;
        for (int r = 0; r < KK; r++) begin
            for (int c = 0; c < KK; c++) begin
                res[DW*(r*KK+c) +: DW] = img[rr-KK+1+r][cc-KK+1+c];
            end
        end
        return res;
    endfunction

    function automatic int unsigned window_sum(input logic [AW-1:0] v);
        int unsigned acc;
        acc = 0;
        for (int e = 0; e < KK*KK; e++) begin
            acc += v[DW*e +: DW];
        end
        return acc;
    endfunction

    task automatic check_outputs();
        check_eq("wv_s1", AW'(bus_a.win_valid), AW'(exp_wv[0]));
        check_eq("wv_s2", AW'(bus_b.win_valid), AW'(exp_wv[1]));
        check_eq("fd_s1", AW'(bus_a.frame_done), AW'(exp_fd));
        check_eq("fd_s2", AW'(bus_b.frame_done), AW'(exp_fd));
        if (exp_wv[0]) begin
            check_eq("act_s1", bus_a.activation1, exp_act[0]);
            if (frame_base == 0 && win_idx_a == 0) begin
                check_eq("sum_first", AW'(window_sum(bus_a.activation1)), AW'(54));
            end
            win_idx_a++;
        end
        if (exp_wv[1]) begin
            check_eq("act_s2", bus_b.activation1, exp_act[1]);
        end
        if (bus_a.win_valid) win_cnt[0]++;
        if (bus_b.win_valid) win_cnt[1]++;
        if (bus_a.frame_done) fd_seen++;
        if (exp_fd) begin
            check_eq("nwin_s1", AW'(win_cnt[0]), AW'(((IH-KK)/1+1) * ((IW-KK)/1+1)));
            check_eq("nwin_s2", AW'(win_cnt[1]), AW'(((IH-KK)/2+1) * ((IW-KK)/2+1)));
            win_cnt[0] = 0;
            win_cnt[1] = 0;
        end
    endtask

    // One clock: drive, let the edge happen, update the reference, compare.
    task automatic step(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        pix_valid = v;
        pix_in    = d;
        @(posedge clk);
        exp_wv[0] = 1'b0;
        exp_wv[1] = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            img[mr][mc] = d;
            for (int i = 0; i < 2; i++) begin
                if (mr >= KK-1 && mc >= KK-1 &&
                    (mr-KK+1) % (i+1) == 0 && (mc-KK+1) % (i+1) == 0) begin
                    exp_wv[i]  = 1'b1;
                    exp_act[i] = model_window(mr, mc);
                end
            end
            if (mr == IH-1 && mc == IW-1) begin
                exp_fd = 1'b1;
                fd_exp_total++;
            end
            mc++;
            if (mc == IW) begin
                mc = 0;
                mr++;
                if (mr == IH) mr = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    // base < 0 selects random pixel values; pct is the bubble probability.
    task automatic send_frame(input int base, input int npix, input int pct);
        frame_base = base;
        win_idx_a  = 0;
        for (int p = 0; p < npix; p++) begin
            for (int nb = 0; nb < 6 && int'($urandom_range(99)) < pct; nb++) begin
                step(1'b0, $urandom);
            end
            step(1'b1, (base < 0) ? $urandom : DW'(base + p));
        end
    endtask

    // Asynchronous assert mid-cycle; outputs must clear before the next edge.
    task automatic apply_reset();
        @(negedge clk);
        pix_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check_eq("rst_wv_s1", AW'(bus_a.win_valid), '0);
        check_eq("rst_wv_s2", AW'(bus_b.win_valid), '0);
        check_eq("rst_fd_s1", AW'(bus_a.frame_done), '0);
        check_eq("rst_fd_s2", AW'(bus_b.frame_done), '0);
        check_eq("rst_act_s1", bus_a.activation1, '0);
        check_eq("rst_act_s2", bus_b.activation1, '0);
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        mr         = 0;
        mc         = 0;
        win_cnt[0] = 0;
        win_cnt[1] = 0;
        exp_wv[0]  = 1'b0;
        exp_wv[1]  = 1'b0;
    endtask

    initial begin
        win_cnt[0] = 0;
        win_cnt[1] = 0;
        repeat (2) @(posedge clk);
        apply_reset();

        send_frame(0, IW*IH, 0);
        send_frame(0, IW*IH, 50);
        send_frame(100, IW*IH, 0);
        send_frame(-1, IW*IH, 40);

        send_frame(0, 14, 0);
        apply_reset();
        send_frame(0, IW*IH, 0);

        for (int f = 0; f < 3; f++) begin
            send_frame(-1, IW*IH, int'($urandom_range(70)));
        end
        step(1'b0, '0);

        check_eq("fd_total", AW'(fd_seen), AW'(fd_exp_total));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that sits directly upstream of the k×k convolution MAC stage. It accepts a raster-order pixel stream (one pixel per cycle, gaps allowed) and buffers k−1 full image rows plus a k×k window register. When a complete window at a stride-aligned position is available, it presents the window as a packed k·k·data_width vector with a one-cycle `win_valid` strobe. The packed vector drives the convolution stage's activation input and `win_valid` drives its `ce`.

## Interface
- `data_width`, 32: bits per pixel.
- `k`, 3: kernel/window size (k ≥ 2).
- `s`, 1: stride, equal horizontally and vertically (1 ≤ s ≤ k).
- `img_w`, 8: image width in pixels (img_w ≥ k).
- `img_h`, 8: image height in pixels (img_h ≥ k).

- `clk`  in  1  single clock; all logic on rising edge.
- `global_rst`  in  1  asynchronous, active-high reset.
- `pix_in`  in  data_width  input pixel, raster order.
- `pix_valid`  in  1  `pix_in` is accepted this cycle; no backpressure.
- `activation1`  out  k·k·data_width  packed window; element index `r*k+c` at bits `[data_width*(r*k+c) +: data_width]`; r=0 is the top (oldest) row, c=0 is the left (oldest) column.
- `win_valid`  out  1  one-cycle strobe; `activation1` holds a valid window.
- `frame_done`  out  1  one-cycle strobe after the last pixel of a frame is accepted.

## Operation
- Counters `col` (0..img_w−1) and `row` (0..img_h−1) advance only on accepted pixels (`pix_valid`=1).
  - `col` wraps to 0 and increments `row`.
  - After (img_h−1, img_w−1), both counters return to 0 and the next frame starts immediately.
- Line buffers: k−1 rows of img_w entries, with combinational read addressed by `col`. On an accepted pixel at column c:
  - The new window column, top to bottom, is {lb[k−2][c], …, lb[0][c], pix_in}.
  - Then lb[j][c] ← lb[j−1][c] and lb[0][c] ← pix_in.
- Window register: on an accepted pixel, every window row shifts left by one column. The new column enters at c=k−1.
- A window is complete when the accepted pixel at (R, C) satisfies all of the following:
  - R ≥ k−1 and C ≥ k−1.
  - (R−k+1) mod s = 0 and (C−k+1) mod s = 0.
  - Both stride conditions are tracked with stride phase counters, not a divider. Phase counters reset at col=0 or row=0 respectively.
- The window then covers rows R−k+1..R and columns C−k+1..C.
- Stale columns carried over from the previous row, and stale line-buffer contents from the previous frame, only ever sit in positions where the window is not complete. Buffers are therefore never cleared between rows or frames.
- Windows per frame = ((img_h−k)/s+1)·((img_w−k)/s+1), using integer division.

## Timing
- Reset values: `activation1`=0, `win_valid`=0, `frame_done`=0, counters=0, phase counters=0, window registers=0.
  - Line-buffer contents after reset are don't-care.
  - Reset asserted mid-frame discards the partial frame. The first accepted pixel after release is (0,0).
- Latency: `win_valid` and the updated `activation1` appear on the cycle after the accepting edge, i.e. registered outputs with 1-cycle latency.
- `activation1` holds its value until the next accepted pixel. `win_valid` is high for exactly one cycle per complete window.
- `pix_valid`=0 cycles (bubbles): no state changes, `win_valid`=0, output values identical to a gap-free stream.
- `frame_done` asserts 1 cycle after the accepting edge of pixel (img_h−1, img_w−1). It may coincide with the last `win_valid`.
- Maximum throughput: one window per cycle (s=1, stream with no gaps).

## Structure
- Shared package `conv_pkg`:
  - `data_width` and `k` defaults, shared with the convolution stage.
  - Counter width constants via clog2 of img_w, img_h and s.
  - The packing-index convention r*k+c.
- One natural sub-module, `line_buffer`: a single img_w×data_width row store with combinational read and synchronous write, shared address. Instantiate it k−1 times in a generate loop.
- Window register, counters and stride phase logic live in the top module.

## Test plan
- Reset, k=3, s=1, img_w=img_h=5, pixels 0..24 with no gaps:
  - First `win_valid` 1 cycle after pixel 12 is accepted, with `activation1` elements 0..8 = 0,1,2,5,6,7,10,11,12.
  - Exactly 9 windows.
  - `frame_done` 1 cycle after pixel 24, coinciding with the last window (12,13,14,17,18,19,22,23,24).
- Same frame with s=2 → exactly 4 windows, at (R,C) = (2,2), (2,4), (4,2), (4,4). The last window is 12,13,14,17,18,19,22,23,24.
- Same frame with random `pix_valid` bubbles (≈50%) → window sequence and contents identical to the no-gap run; `win_valid` never high during or after a bubble without a new accept.
- Two back-to-back frames (second frame uses values 100..124) → second frame windows contain only 100..124 values; no stale data from frame 1; 9 windows; 2 `frame_done` pulses total.
- Assert `global_rst` after pixel 13 of a frame → all outputs 0 within the reset cycle. A fresh 0..24 frame after release reproduces the first scenario exactly.
- Connect to the convolution stage with all weights=1, s=1, 5×5 → convolution outputs the 3×3 window sums. The first sum is 54 (0+1+2+5+6+7+10+11+12).
